// File: rtl/sw_pkg.sv
// ============================================================================
// sw_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the Smith-Waterman datapath: default sequence
// capacities, score width, the sequence-loader state enum and the per-frame
// byte counts (RB ref bytes, QB read bytes) derived from the defaults.
// Used by SW_core, sw_seq_loader and the bench.
// ============================================================================
package sw_pkg;

    // Default capacities in bases; multiples of 4 and no larger than 255.
    localparam int REF_MAX_LENGTH_DEFAULT  = 128;
    localparam int READ_MAX_LENGTH_DEFAULT = 128;

    localparam int DP_SW_SCORE_BITWIDTH = 10;

    // Four 2-bit bases per host byte.
    localparam int RB = REF_MAX_LENGTH_DEFAULT / 4;
    localparam int QB = READ_MAX_LENGTH_DEFAULT / 4;

    typedef enum logic [2:0] {
        S_LREF  = 3'd0,   // waiting for the ref length byte
        S_LREAD = 3'd1,   // waiting for the read length byte
        S_REF   = 3'd2,   // shifting in ref bytes
        S_READ  = 3'd3,   // shifting in read bytes
        S_ISSUE = 3'd4    // job presented to the core
    } sw_ld_state_t;

    // Byte counter width for the larger of the two payloads, never zero.
    function automatic int cnt_width(input int rb, input int qb);
        int m;
        m = (rb > qb) ? rb : qb;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sw_byte_packer.sv
// ============================================================================
// sw_byte_packer
// ----------------------------------------------------------------------------
// Shift register that packs a byte stream into a wide word. Each loaded byte
// enters at the LSB and older bytes move toward the MSB, so after WIDTH/8
// loads the first byte of the stream sits in the top byte.
//
// Ports:
//   clk    in  1      clock
//   rst    in  1      asynchronous active-high reset
//   clear  in  1      synchronous clear, wins over load
//   load   in  1      shift data in this cycle
//   data   in  8      byte to shift in
//   q      out WIDTH  packed word
// ============================================================================
module sw_byte_packer #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] q
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its inputs, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= (q << 8) | WIDTH'(data);
        end
    end

endmodule

// File: rtl/sw_seq_loader.sv
// ============================================================================
// sw_seq_loader
// ----------------------------------------------------------------------------
// Receives one ref/read job as a host byte stream and presents it to SW_core
// as MSB-aligned packed sequences plus 1-based lengths, with a valid/ready
// handshake.
//
// Frame: ref length, read length, REF_MAX_LENGTH/4 ref bytes,
//        READ_MAX_LENGTH/4 read bytes (4 bases per byte, first base in MSBs).
//
// Ports:
//   clk                in  1   clock
//   rst                in  1   asynchronous active-high reset
//   i_data             in  8   host byte
//   i_data_valid       in  1   host byte valid
//   o_data_ready       out 1   loader accepts a byte (low only while issuing)
//   i_core_ready       in  1   SW_core ready
//   o_valid            out 1   job valid toward SW_core
//   o_sequence_ref     out 2*REF_MAX_LENGTH   packed ref (0 unless issuing)
//   o_sequence_read    out 2*READ_MAX_LENGTH  packed read (0 unless issuing)
//   o_seq_ref_length   out clog2(REF_MAX_LENGTH)+1   ref length (0 unless issuing)
//   o_seq_read_length  out clog2(READ_MAX_LENGTH)+1  read length (0 unless issuing)
//   o_err              out 1   one-cycle pulse when a frame is rejected
//
// Build option:
//   SW_LOADER_LENGTH_CHECK_EN  reject frames whose lengths are 0 or above the
//                              capacity; without it o_err is tied low and the
//                              lengths pass through unchecked.
// ============================================================================
module sw_seq_loader
    import sw_pkg::*;
#(
    parameter int REF_MAX_LENGTH  = REF_MAX_LENGTH_DEFAULT,
    parameter int READ_MAX_LENGTH = READ_MAX_LENGTH_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         i_data,
    input  logic                               i_data_valid,
    output logic                               o_data_ready,
    input  logic                               i_core_ready,
    output logic                               o_valid,
    output logic [2*REF_MAX_LENGTH-1:0]        o_sequence_ref,
    output logic [2*READ_MAX_LENGTH-1:0]       o_sequence_read,
    output logic [$clog2(REF_MAX_LENGTH):0]    o_seq_ref_length,
    output logic [$clog2(READ_MAX_LENGTH):0]   o_seq_read_length,
    output logic                               o_err
);

    localparam int REF_BYTES  = REF_MAX_LENGTH / 4;
    localparam int READ_BYTES = READ_MAX_LENGTH / 4;
    localparam int CNT_W      = cnt_width(REF_BYTES, READ_BYTES);
    localparam int RLW        = $clog2(REF_MAX_LENGTH) + 1;
    localparam int QLW        = $clog2(READ_MAX_LENGTH) + 1;

    sw_ld_state_t state_q, state_d;

    logic [CNT_W-1:0]             cnt_q;
    logic [7:0]                   len_ref_q;
    logic [7:0]                   len_read_q;
    logic [2*REF_MAX_LENGTH-1:0]  ref_word;
    logic [2*READ_MAX_LENGTH-1:0] read_word;

    logic accept;
    logic last_ref;
    logic last_read;
    logic lengths_ok;
    logic clear_seq;

    assign accept    = i_data_valid && o_data_ready;
    assign last_ref  = (cnt_q == CNT_W'(REF_BYTES - 1));
    assign last_read = (cnt_q == CNT_W'(READ_BYTES - 1));

`ifdef SW_LOADER_LENGTH_CHECK_EN
    // Full received byte is checked, so oversize lengths are caught even when
    // the length port is narrower than 8 bits.
    assign lengths_ok = (len_ref_q  != 8'd0) && (len_ref_q  <= 8'(REF_MAX_LENGTH)) &&
                        (len_read_q != 8'd0) && (len_read_q <= 8'(READ_MAX_LENGTH));
`else
    assign lengths_ok = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LREF;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LREF:  if (accept) state_d = S_LREAD;
            S_LREAD: if (accept) state_d = S_REF;
            S_REF:   if (accept && last_ref) state_d = S_READ;
            S_READ:  if (accept && last_read) state_d = lengths_ok ? S_ISSUE : S_LREF;
            S_ISSUE: if (i_core_ready) state_d = S_LREF;
            default: state_d = S_LREF;
        endcase
    end

    // ------------------------------------------------------------------------
    // Byte counter: restarts on every state change, counts accepted payload
    // bytes while in S_REF / S_READ. The terminal count always coincides with
    // a state change, so it never wraps.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (accept && (state_q == S_REF || state_q == S_READ)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Length capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_ref_q  <= '0;
            len_read_q <= '0;
        end else if (accept) begin
            if (state_q == S_LREF)  len_ref_q  <= i_data;
            if (state_q == S_LREAD) len_read_q <= i_data;
        end
    end

    // ------------------------------------------------------------------------
    // Error pulse: registered so it appears as a clean one-cycle pulse in the
    // first S_LREF cycle after a rejected frame.
    // ------------------------------------------------------------------------
`ifdef SW_LOADER_LENGTH_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == S_READ) && accept && last_read && !lengths_ok;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Packers. Cleared whenever the FSM re-enters S_LREF (after a handshake or
    // a rejected frame) so every frame starts from zero; clear wins over the
    // final read-byte load of a rejected frame.
    // ------------------------------------------------------------------------
    assign clear_seq = (state_d == S_LREF) && (state_q != S_LREF);

    sw_byte_packer #(
        .WIDTH (2*REF_MAX_LENGTH)
    ) u_ref_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_seq),
        .load  (accept && (state_q == S_REF)),
        .data  (i_data),
        .q     (ref_word)
    );

    sw_byte_packer #(
        .WIDTH (2*READ_MAX_LENGTH)
    ) u_read_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_seq),
        .load  (accept && (state_q == S_READ)),
        .data  (i_data),
        .q     (read_word)
    );

    // ------------------------------------------------------------------------
    // Outputs. Decoded from the state register only, so they are glitch-free,
    // stable for the whole issue window and drop with an asynchronous reset.
    // ------------------------------------------------------------------------
    always_comb begin
        o_valid           = 1'b0;
        o_data_ready      = 1'b1;
        o_sequence_ref    = '0;
        o_sequence_read   = '0;
        o_seq_ref_length  = '0;
        o_seq_read_length = '0;
        if (state_q == S_ISSUE) begin
            o_valid           = 1'b1;
            o_data_ready      = 1'b0;
            o_sequence_ref    = ref_word;
            o_sequence_read   = read_word;
            o_seq_ref_length  = RLW'(len_ref_q);
            o_seq_read_length = QLW'(len_read_q);
        end
    end

endmodule

// File: tb/tb_sw_seq_loader.sv
`timescale 1ns/1ps
module tb_sw_seq_loader;
    import sw_pkg::*;

    localparam int RMAX   = REF_MAX_LENGTH_DEFAULT;
    localparam int QMAX   = READ_MAX_LENGTH_DEFAULT;
    localparam int RW     = 2*RMAX;
    localparam int QW     = 2*QMAX;
    localparam int RLW    = $clog2(RMAX) + 1;
    localparam int QLW    = $clog2(QMAX) + 1;
    localparam int BUDGET = 200;

    typedef struct {
        logic [RW-1:0] sref;
        logic [QW-1:0] sread;
        logic [7:0]    lr;
        logic [7:0]    lq;
    } job_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          i_data;
    logic                i_data_valid;
    logic                o_data_ready;
    logic                core_ready;
    logic                o_valid;
    logic [RW-1:0]       o_sequence_ref;
    logic [QW-1:0]       o_sequence_read;
    logic [RLW-1:0]      o_seq_ref_length;
    logic [QLW-1:0]      o_seq_read_length;
    logic                o_err;

    job_t exp_q[$];
    int   vectors      = 0;
    int   miscompares  = 0;
    int   hs_count     = 0;
    int   err_count    = 0;
    int   accept_count = 0;
    logic last_pre_valid;

    always #5 clk = ~clk;

    sw_seq_loader #(
        .REF_MAX_LENGTH  (RMAX),
        .READ_MAX_LENGTH (QMAX)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_data            (i_data),
        .i_data_valid      (i_data_valid),
        .o_data_ready      (o_data_ready),
        .i_core_ready      (core_ready),
        .o_valid           (o_valid),
        .o_sequence_ref    (o_sequence_ref),
        .o_sequence_read   (o_sequence_read),
        .o_seq_ref_length  (o_seq_ref_length),
        .o_seq_read_length (o_seq_read_length),
        .o_err             (o_err)
    );

    // ------------------------------------------------------------------------
    // Monitor: samples 2 ns after each falling edge, after the drivers settle.
    // Pops the scoreboard on every handshake and checks the idle cycle after.
    // ------------------------------------------------------------------------
    initial begin : monitor
        job_t e;
        bit   prev_hs;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b0) begin
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) begin
                    vectors++;
                    if (o_valid !== 1'b0 || o_sequence_ref !== '0 || o_sequence_read !== '0 ||
                        o_seq_ref_length !== '0 || o_seq_read_length !== '0) begin
                        miscompares++;
                        $display("FAIL post_handshake_idle: o_valid=%b ref_len=%0d read_len=%0d, expected all zero",
                                 o_valid, o_seq_ref_length, o_seq_read_length);
                    end
                end
                prev_hs = 1'b0;
                if (i_data_valid === 1'b1 && o_data_ready === 1'b1) accept_count++;
                if (o_err === 1'b1) err_count++;
                if (o_valid === 1'b1 && core_ready === 1'b1) begin
                    prev_hs = 1'b1;
                    hs_count++;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_job: ref_len=%0d read_len=%0d, expected no job",
                                 o_seq_ref_length, o_seq_read_length);
                    end else begin
                        e = exp_q.pop_front();
                        if (o_sequence_ref !== e.sref || o_sequence_read !== e.sread ||
                            o_seq_ref_length !== RLW'(e.lr) || o_seq_read_length !== QLW'(e.lq)) begin
                            miscompares++;
                            $display("FAIL job_data: got len %0d/%0d ref %h read %h, expected len %0d/%0d ref %h read %h",
                                     o_seq_ref_length, o_seq_read_length, o_sequence_ref, o_sequence_read,
                                     e.lr, e.lq, e.sref, e.sread);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (entered and left on a falling edge)
    // ------------------------------------------------------------------------
    function automatic job_t make_const(input logic [7:0] lr, input logic [7:0] lq,
                                        input logic [7:0] rb, input logic [7:0] qb);
        job_t j;
        j.lr = lr;
        j.lq = lq;
        for (int k = 0; k < RB; k++) j.sref[RW-1-8*k -: 8] = rb;
        for (int k = 0; k < QB; k++) j.sread[QW-1-8*k -: 8] = qb;
        return j;
    endfunction

    function automatic job_t make_rand();
        job_t j;
        j.lr = 8'($urandom_range(1, RMAX));
        j.lq = 8'($urandom_range(1, QMAX));
        for (int k = 0; k < RB; k++) j.sref[RW-1-8*k -: 8] = 8'($urandom_range(0, 255));
        for (int k = 0; k < QB; k++) j.sread[QW-1-8*k -: 8] = 8'($urandom_range(0, 255));
        return j;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        i_data       = b;
        i_data_valid = 1'b1;
        while (o_data_ready !== 1'b1 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        if (t >= BUDGET) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_timeout: o_data_ready=%b for %0d cycles, expected 1", o_data_ready, t);
        end
        @(negedge clk);
    endtask

    task automatic gap_cycle(input bit gap);
        if (gap) begin
            i_data_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input job_t j, input bit gap, input bit push);
        if (push) exp_q.push_back(j);
        send_byte(j.lr);
        gap_cycle(gap);
        send_byte(j.lq);
        for (int k = 0; k < RB; k++) begin
            gap_cycle(gap);
            send_byte(j.sref[RW-1-8*k -: 8]);
        end
        for (int k = 0; k < QB; k++) begin
            gap_cycle(gap);
            if (k == QB-1) last_pre_valid = o_valid;
            send_byte(j.sread[QW-1-8*k -: 8]);
        end
        i_data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_handshakes(input string name, input int h0, input int n);
        vectors++;
        if (hs_count - h0 !== n || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL %s_handshakes: got %0d handshakes, %0d pending; expected %0d, 0 pending",
                     name, hs_count - h0, exp_q.size(), n);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst          = 1'b1;
        i_data       = 8'h00;
        i_data_valid = 1'b0;
        core_ready   = 1'b1;
        idle(3);
        vectors++;
        if (o_valid !== 1'b0 || o_data_ready !== 1'b1 || o_err !== 1'b0 ||
            o_sequence_ref !== '0 || o_sequence_read !== '0 ||
            o_seq_ref_length !== '0 || o_seq_read_length !== '0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b ready=%b err=%b lens=%0d/%0d, expected 0/1/0 and zero buses",
                     o_valid, o_data_ready, o_err, o_seq_ref_length, o_seq_read_length);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_single_frame();
        int h0;
        h0 = hs_count;
        core_ready = 1'b1;
        send_frame(make_const(8'd128, 8'd128, 8'h1B, 8'hE4), 1'b0, 1'b1);
        vectors++;
        if (last_pre_valid !== 1'b0 || o_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL single_valid_timing: before last byte %b, after %b; expected 0 then 1",
                     last_pre_valid, o_valid);
        end
        idle(3);
        check_handshakes("single", h0, 1);
    endtask

    task automatic test_backpressure();
        job_t j;
        int   h0;
        h0 = hs_count;
        j  = make_const(8'd128, 8'd128, 8'h1B, 8'hE4);
        core_ready = 1'b0;
        send_frame(j, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (o_valid !== 1'b1 || o_data_ready !== 1'b0 || o_sequence_ref !== j.sref ||
                o_sequence_read !== j.sread || o_seq_ref_length !== RLW'(j.lr) ||
                o_seq_read_length !== QLW'(j.lq)) begin
                miscompares++;
                $display("FAIL backpressure_hold: cycle %0d valid=%b ready=%b lens=%0d/%0d, expected 1/0 and stable job",
                         i, o_valid, o_data_ready, o_seq_ref_length, o_seq_read_length);
            end
            @(negedge clk);
        end
        vectors++;
        if (hs_count !== h0) begin
            miscompares++;
            $display("FAIL backpressure_early: %0d handshakes while not ready, expected 0", hs_count - h0);
        end
        core_ready = 1'b1;
        idle(1);
        vectors++;
        if (o_data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_handshake: o_data_ready=%b, expected 1", o_data_ready);
        end
        idle(2);
        check_handshakes("backpressure", h0, 1);
    endtask

    task automatic test_gapped();
        int h0, a0;
        h0 = hs_count;
        a0 = accept_count;
        core_ready = 1'b1;
        send_frame(make_const(8'd128, 8'd128, 8'h1B, 8'hE4), 1'b1, 1'b1);
        vectors++;
        if (last_pre_valid !== 1'b0 || o_valid !== 1'b1 || accept_count - a0 !== 2 + RB + QB) begin
            miscompares++;
            $display("FAIL gapped_latency: pre %b post %b accepts %0d, expected 0, 1, %0d",
                     last_pre_valid, o_valid, accept_count - a0, 2 + RB + QB);
        end
        idle(3);
        check_handshakes("gapped", h0, 1);
    endtask

    task automatic test_reset_midframe();
        job_t stale;
        int   h0;
        h0    = hs_count;
        stale = make_rand();
        core_ready = 1'b1;
        send_byte(stale.lr);
        send_byte(stale.lq);
        for (int k = 0; k < 38; k++) send_byte(stale.sref[RW-1-8*k -: 8]);
        i_data_valid = 1'b0;
        rst = 1'b1;
        idle(1);
        vectors++;
        if (o_valid !== 1'b0 || o_data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe_reset: valid=%b ready=%b, expected 0/1", o_valid, o_data_ready);
        end
        rst = 1'b0;
        idle(1);
        send_frame(make_rand(), 1'b0, 1'b1);
        idle(3);
        check_handshakes("midframe_reset", h0, 1);
    endtask

    task automatic test_reset_issue();
        int h0;
        h0 = hs_count;
        core_ready = 1'b0;
        send_frame(make_rand(), 1'b0, 1'b0);
        vectors++;
        if (o_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_reached: o_valid=%b, expected 1", o_valid);
        end
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (o_valid !== 1'b0 || o_sequence_ref !== '0) begin
            miscompares++;
            $display("FAIL async_reset_valid: o_valid=%b, expected 0 right after reset", o_valid);
        end
        @(negedge clk);
        rst        = 1'b0;
        core_ready = 1'b1;
        idle(3);
        check_handshakes("issue_reset", h0, 0);
    endtask

    task automatic test_length_check();
        int h0, e0;
        h0 = hs_count;
        e0 = err_count;
        core_ready = 1'b1;
`ifdef SW_LOADER_LENGTH_CHECK_EN
        send_frame(make_const(8'd0, 8'd128, 8'h55, 8'hAA), 1'b0, 1'b0);
        idle(2);
        vectors++;
        if (err_count - e0 !== 1) begin
            miscompares++;
            $display("FAIL err_ref_len0: %0d pulses, expected 1", err_count - e0);
        end
        send_frame(make_const(8'd128, 8'd200, 8'h55, 8'hAA), 1'b0, 1'b0);
        idle(2);
        vectors++;
        if (err_count - e0 !== 2) begin
            miscompares++;
            $display("FAIL err_read_len200: %0d pulses, expected 2", err_count - e0);
        end
        send_frame(make_rand(), 1'b0, 1'b1);
        idle(3);
        check_handshakes("length_check", h0, 1);
`else
        send_frame(make_const(8'd200, 8'd128, 8'h55, 8'hAA), 1'b0, 1'b1);
        idle(3);
        vectors++;
        if (err_count !== 0) begin
            miscompares++;
            $display("FAIL err_tied_low: %0d pulses, expected 0", err_count);
        end
        check_handshakes("length_passthru", h0, 1);
`endif
    endtask

    task automatic test_back_to_back();
        int h0;
        h0 = hs_count;
        core_ready = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(make_rand(), 1'b0, 1'b1);
        idle(3);
        check_handshakes("back_to_back", h0, 3);
    endtask

    initial begin : main
        test_reset();
        test_single_frame();
        test_backpressure();
        test_gapped();
        test_reset_midframe();
        test_reset_issue();
        test_length_check();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sw_seq_loader.md
# sw_seq_loader

Upstream feeder for `SW_core`. It receives one ref/read job as a byte stream from the host interface and packs it into the parallel, MSB-aligned sequence and length buses the core expects. It then issues the job to the core with a valid/ready handshake. It sits between the host byte interface (RS232/Avalon bridge) and `SW_core`, and replaces the bench-driven stimulus path.

## Interface
Parameters:
- `REF_MAX_LENGTH`, default 128: reference capacity in bases. Must be a multiple of 4 and ≤ 255.
- `READ_MAX_LENGTH`, default 128: read capacity in bases. Must be a multiple of 4 and ≤ 255.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `i_data`  in  8: host byte.
- `i_data_valid`  in  1: `i_data` is valid this cycle.
- `o_data_ready`  out  1: loader accepts a byte this cycle.
- `i_core_ready`  in  1: connected to `SW_core.o_ready`.
- `o_valid`  out  1: job valid; connected to `SW_core.i_valid`.
- `o_sequence_ref`  out  2*REF_MAX_LENGTH: packed reference, MSB-aligned.
- `o_sequence_read`  out  2*READ_MAX_LENGTH: packed read, MSB-aligned.
- `o_seq_ref_length`  out  $clog2(REF_MAX_LENGTH)+1: reference length, 1-based.
- `o_seq_read_length`  out  $clog2(READ_MAX_LENGTH)+1: read length, 1-based.
- `o_err`  out  1: one-cycle pulse when a frame is rejected.

## Operation
- Frame layout, in this order:
  - byte 0: ref length
  - byte 1: read length
  - next RB = REF_MAX_LENGTH/4 bytes: ref
  - next QB = READ_MAX_LENGTH/4 bytes: read
- Bytes are first-in-MSB. Each byte holds 4 bases, 2 bits per base. Bases beyond the stated length are don't-care but are passed through unchanged; the host sends zeros there.
- A byte transfers when `i_data_valid && o_data_ready`.
- FSM:
  - `S_LREF`: capture ref length → `S_LREAD`.
  - `S_LREAD`: capture read length → `S_REF`.
  - `S_REF`: shift-in bytes; byte counter 0..RB-1; on the last byte → `S_READ`.
  - `S_READ`: same, counter 0..QB-1; on the last byte → `S_ISSUE`.
  - `S_ISSUE`: `o_valid` = 1; on `i_core_ready` → `S_LREF`.
- `o_data_ready` = 1 in every state except `S_ISSUE`. No bytes are buffered during issue; the host stalls.
- Sequence and length outputs:
  - They are driven from internal registers only in `S_ISSUE`, and are 0 otherwise.
  - They are stable for the whole time `o_valid` is high.
- Shift registers clear on entry to `S_LREF`, so each frame starts from zero.
- Byte counter width is $clog2(max(RB,QB)). It resets to 0 on each state change; there is no wrap beyond the terminal count.

## Timing
- Reset values: `o_valid`=0, `o_data_ready`=1 (state `S_LREF`), all sequence and length outputs 0, `o_err`=0.
- Reset mid-frame discards the partial frame. Reset during `S_ISSUE` drops `o_valid` asynchronously and the job is lost.
- `o_valid` rises at the clock edge after the last read byte is accepted. Latency = 2+RB+QB accepted bytes + 1 cycle.
- Handshake completes in the cycle with `o_valid && i_core_ready`. `o_valid` and the buses return to 0 on the next edge. `o_valid` never drops before acceptance.
- If `i_core_ready` is already 1 on entry to `S_ISSUE`, `o_valid` is high for exactly 1 cycle.
- `o_data_ready` returns to 1 in the cycle after the handshake. Back-to-back frames lose exactly one byte slot plus the issue wait.
- `i_data_valid` gaps are allowed anywhere; the state and counters hold.

## Configuration
- Macro: `SW_LOADER_LENGTH_CHECK_EN`.
- With the macro defined: on the last read byte, each length is checked.
  - A ref length of 0 or greater than REF_MAX_LENGTH fails. A read length of 0 or greater than READ_MAX_LENGTH fails.
  - On failure, the FSM goes to `S_LREF` instead of `S_ISSUE`, `o_err` pulses 1 cycle, and no job is issued. The whole frame is still consumed.
- Without the macro: no check is made, lengths pass through as received, and `o_err` is tied to 0.

## Structure
- `sw_pkg`: `REF_MAX_LENGTH`/`READ_MAX_LENGTH` defaults, `DP_SW_SCORE_BITWIDTH`, the loader state enum `sw_ld_state_t`, and the byte-count localparams RB/QB. Shared with `SW_core` and the bench.
- One sub-module: `sw_byte_packer #(WIDTH)`.
  - It is a shift register with load-enable and clear, and shifts 8 bits in at the LSB.
  - It is instantiated twice, once for ref and once for read.

## Test plan
- One frame: lengths 128/128, ref bytes all 0x1B, read bytes all 0xE4, core ready held at 1 → 1-cycle `o_valid`; `o_sequence_ref` = {32{8'h1B}}; lengths 128/128; buses 0 the next cycle.
- Backpressure: same frame with `i_core_ready`=0 for 20 cycles after `o_valid` → `o_valid` and buses held constant; `o_data_ready`=0 throughout; handshake on the first ready cycle.
- Gapped input: `i_data_valid` toggling 1/0 every cycle → result identical to the gapless case; `o_valid` appears after 66 accepts + 1 cycle.
- Reset: assert `rst` after byte 40 of a frame, then send a fresh full frame → only the second frame is issued, with correct data.
- Length check (macro on): ref length 0, then read length 200 (with the 128 default) → `o_err` pulses once per frame, no `o_valid`, and the next valid frame issues normally. With the macro off, a ref length of 200 is issued as 200.
- Back-to-back: 3 frames streamed continuously → 3 handshakes in order, each with that frame's data.
